// File: rtl/playseq_condiciona_entradas.sv
// rtl/playseq_condiciona_entradas.sv - input conditioning: synchronizers, button debounce FSM, start-button debouncer
module playseq_condiciona_entradas #(
  parameter int N_DEB = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       jogar_in,
  output logic [3:0] botoes,
  output logic       jogada,
  output logic       jogar,
  output logic       db_multiplo,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'b00,
    FILTRANDO   = 2'b01,
    PRESSIONADO = 2'b10,
    SOLTANDO    = 2'b11
  } state_t;

  // Last count value of the window; reaching it with a stable sample completes the filter
  localparam logic [7:0] LAST = 8'(N_DEB - 1);

  logic [3:0] bot_meta;
  logic [3:0] bot_sync;
  logic       jog_meta;
  logic       jog_sync;

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] cand;

  logic [7:0] jcnt;
  logic       jlevel;

  logic       bot_zero;
  logic       bot_multi;
  logic       bot_onehot;

  assign bot_zero    = (bot_sync == 4'b0000);
  assign bot_multi   = ((bot_sync & (bot_sync - 4'd1)) != 4'b0000);
  assign bot_onehot  = !bot_zero && !bot_multi;
  assign db_multiplo = bot_multi;
  assign db_estado   = state;

  // Two-flop synchronizers for the raw asynchronous inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bot_meta <= 4'b0000;
      bot_sync <= 4'b0000;
      jog_meta <= 1'b0;
      jog_sync <= 1'b0;
    end else begin
      bot_meta <= botoes_in;
      bot_sync <= bot_meta;
      jog_meta <= jogar_in;
      jog_sync <= jog_meta;
    end
  end

  // Button FSM: accept a one-hot press after a full stable window, then filter its release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= OCIOSO;
      cnt    <= 8'd0;
      cand   <= 4'b0000;
      botoes <= 4'b0000;
      jogada <= 1'b0;
    end else begin
      jogada <= 1'b0;
      unique case (state)
        OCIOSO: begin
          if (bot_onehot) begin
            state <= FILTRANDO;
            cand  <= bot_sync;
            cnt   <= 8'd1;
          end
        end
        FILTRANDO: begin
          if (bot_sync != cand) begin
            state <= OCIOSO;
            cnt   <= 8'd0;
          end else if (cnt == LAST) begin
            state  <= PRESSIONADO;
            botoes <= cand;
            jogada <= 1'b1;
          end else if (cnt != 8'hff) begin
            cnt <= cnt + 8'd1;
          end
        end
        PRESSIONADO: begin
          // A different or multi-hot value while held is not a new press
          if (bot_zero) begin
            state <= SOLTANDO;
            cnt   <= 8'd1;
          end
        end
        SOLTANDO: begin
          if (!bot_zero) begin
            state <= PRESSIONADO;
            cnt   <= 8'd0;
          end else if (cnt == LAST) begin
            state  <= OCIOSO;
            botoes <= 4'b0000;
            cnt    <= 8'd0;
          end else if (cnt != 8'hff) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= OCIOSO;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Start-button level debouncer with a registered pulse on the debounced rising edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jcnt   <= 8'd0;
      jlevel <= 1'b0;
      jogar  <= 1'b0;
    end else begin
      jogar <= 1'b0;
      if (jog_sync != jlevel) begin
        if (jcnt == LAST) begin
          jlevel <= jog_sync;
          jcnt   <= 8'd0;
          jogar  <= jog_sync;
        end else if (jcnt != 8'hff) begin
          jcnt <= jcnt + 8'd1;
        end
      end else begin
        jcnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_playseq_condiciona_entradas.sv
// tb/tb_playseq_condiciona_entradas.sv - directed self-checking bench for playseq_condiciona_entradas
module tb_playseq_condiciona_entradas;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_in;
  logic       jogar_in;
  logic [3:0] botoes;
  logic       jogada;
  logic       jogar;
  logic       db_multiplo;
  logic [1:0] db_estado;

  int tests;
  int fails;

  playseq_condiciona_entradas #(.N_DEB(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes_in  (botoes_in),
    .jogar_in   (jogar_in),
    .botoes     (botoes),
    .jogada     (jogada),
    .jogar      (jogar),
    .db_multiplo(db_multiplo),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    botoes_in = 4'b0000;
    jogar_in = 1'b0;
    tick();
    tick();
    tests++;
    if (botoes !== 4'b0000 || jogada !== 1'b0 || jogar !== 1'b0 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: botoes=%b jogada=%b jogar=%b estado=%b, required 0000 0 0 00",
               botoes, jogada, jogar, db_estado);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_press();
    logic [1:0] exp_st [1:6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    int early;
    early = 0;
    botoes_in = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      tests++;
      if (db_estado !== exp_st[i]) begin
        fails++;
        $display("FAIL press_estado edge %0d: got %b, required %b", i, db_estado, exp_st[i]);
      end
      if (i < 6 && (jogada !== 1'b0 || botoes !== 4'b0000)) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL press_early: %0d early edges with output, required 0", early);
    end
    tests++;
    if (botoes !== 4'b0010 || jogada !== 1'b1) begin
      fails++;
      $display("FAIL press_accept: botoes=%b jogada=%b, required 0010 1", botoes, jogada);
    end
    tick();
    tests++;
    if (jogada !== 1'b0 || botoes !== 4'b0010) begin
      fails++;
      $display("FAIL press_pulse_width: jogada=%b botoes=%b, required 0 0010", jogada, botoes);
    end
    botoes_in = 4'b0000;
    for (int i = 1; i <= 5; i++) tick();
    tests++;
    if (botoes !== 4'b0010) begin
      fails++;
      $display("FAIL release_early: botoes=%b after 5 edges, required 0010", botoes);
    end
    tick();
    tests++;
    if (botoes !== 4'b0000 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL release_clear: botoes=%b estado=%b, required 0000 00", botoes, db_estado);
    end
  endtask

  task automatic test_short_glitch();
    int bad;
    bad = 0;
    botoes_in = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    botoes_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (jogada !== 1'b0 || botoes !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL short_glitch: %0d bad edges, estado=%b, required 0 and 00", bad, db_estado);
    end
  endtask

  task automatic test_multi();
    int bad;
    bad = 0;
    botoes_in = 4'b0011;
    tick();
    tick();
    tests++;
    if (db_multiplo !== 1'b1) begin
      fails++;
      $display("FAIL multi_flag: db_multiplo=%b, required 1", db_multiplo);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (jogada !== 1'b0 || botoes !== 4'b0000 || db_estado !== 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL multi_ignored: %0d bad edges, required 0", bad);
    end
    botoes_in = 4'b0000;
    tick();
    tick();
    tests++;
    if (db_multiplo !== 1'b0) begin
      fails++;
      $display("FAIL multi_clear: db_multiplo=%b, required 0", db_multiplo);
    end
  endtask

  task automatic test_release_glitch();
    int bad;
    int pulses;
    bad = 0;
    pulses = 0;
    botoes_in = 4'b1000;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (botoes !== 4'b1000 || jogada !== 1'b1) begin
      fails++;
      $display("FAIL rg_accept: botoes=%b jogada=%b, required 1000 1", botoes, jogada);
    end
    tick();
    tick();
    botoes_in = 4'b0000;
    tick();
    tick();
    botoes_in = 4'b1000;
    tick();
    tests++;
    if (db_estado !== 2'b11) begin
      fails++;
      $display("FAIL rg_soltando: estado=%b, required 11", db_estado);
    end
    if (jogada !== 1'b0 || botoes !== 4'b1000) bad++;
    tick();
    if (jogada !== 1'b0 || botoes !== 4'b1000) bad++;
    tick();
    if (jogada !== 1'b0 || botoes !== 4'b1000) bad++;
    tests++;
    if (db_estado !== 2'b10) begin
      fails++;
      $display("FAIL rg_back_pressed: estado=%b, required 10", db_estado);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (jogada !== 1'b0) pulses++;
      if (botoes !== 4'b1000) bad++;
    end
    tests++;
    if (bad != 0 || pulses != 0) begin
      fails++;
      $display("FAIL rg_hold: %0d botoes errors, %0d extra pulses, required 0 0", bad, pulses);
    end
    botoes_in = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (botoes !== 4'b1000) begin
      fails++;
      $display("FAIL rg_release_early: botoes=%b, required 1000", botoes);
    end
    tick();
    tests++;
    if (botoes !== 4'b0000 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL rg_release: botoes=%b estado=%b, required 0000 00", botoes, db_estado);
    end
  endtask

  task automatic test_jogar();
    int pulses;
    int at;
    for (int round = 0; round < 2; round++) begin
      pulses = 0;
      at = 0;
      jogar_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (jogar === 1'b1) begin
          pulses++;
          at = i;
        end
      end
      tests++;
      if (pulses != 1 || at != 6) begin
        fails++;
        $display("FAIL jogar_press round %0d: %0d pulses at edge %0d, required 1 at 6", round, pulses, at);
      end
      pulses = 0;
      jogar_in = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (jogar !== 1'b0) pulses++;
      end
      tests++;
      if (pulses != 0) begin
        fails++;
        $display("FAIL jogar_release round %0d: %0d pulses, required 0", round, pulses);
      end
    end
  endtask

  task automatic test_reset_mid();
    int at;
    at = 0;
    botoes_in = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (db_estado !== 2'b01) begin
      fails++;
      $display("FAIL mid_filtering: estado=%b, required 01", db_estado);
    end
    reset = 1'b0;
    #2;
    tests++;
    if (botoes !== 4'b0000 || jogada !== 1'b0 || jogar !== 1'b0 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset: botoes=%b jogada=%b jogar=%b estado=%b, required 0000 0 0 00",
               botoes, jogada, jogar, db_estado);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (jogada === 1'b1) at = i;
    end
    tests++;
    if (at != 6 || botoes !== 4'b0001) begin
      fails++;
      $display("FAIL mid_refilter: jogada at edge %0d botoes=%b, required 6 0001", at, botoes);
    end
    botoes_in = 4'b0000;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_back_to_back();
    botoes_in = 4'b0100;
    jogar_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (jogada !== 1'b1 || jogar !== 1'b1 || botoes !== 4'b0100) begin
      fails++;
      $display("FAIL simultaneous: jogada=%b jogar=%b botoes=%b, required 1 1 0100", jogada, jogar, botoes);
    end
    tick();
    tests++;
    if (jogada !== 1'b0 || jogar !== 1'b0) begin
      fails++;
      $display("FAIL simultaneous_width: jogada=%b jogar=%b, required 0 0", jogada, jogar);
    end
    botoes_in = 4'b0000;
    jogar_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_press();
    test_short_glitch();
    test_multi();
    test_release_glitch();
    test_jogar();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/playseq_condiciona_entradas.md
PLAYSEQ_CONDICIONA_ENTRADAS -- requirements
Module: playseq_condiciona_entradas

Interface
REQ-001 SHALL have parameter N_DEB, default 20, giving the debounce window in clock cycles (20 ms at the 1 kHz divided clock); legal range 2..255.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 SHALL have port botoes_in  input  4  raw push-buttons, asynchronous to clock, active-high.
REQ-005 SHALL have port jogar_in  input  1  raw start button, asynchronous, active-high.
REQ-006 SHALL have port botoes  output  4  debounced one-hot button vector, 0000 when no valid press is held.
REQ-007 SHALL have port jogada  output  1  one-cycle pulse marking acceptance of a new valid press.
REQ-008 SHALL have port jogar  output  1  one-cycle pulse on the debounced rising edge of jogar_in.
REQ-009 SHALL have port db_multiplo  output  1  high while the synchronized button vector has more than one bit set.
REQ-010 SHALL have port db_estado  output  2  current button FSM state code.

Function
REQ-011 Each raw input SHALL pass through a two-flip-flop synchronizer; all later logic uses only the synchronized sample S.
REQ-012 The button FSM SHALL have the states OCIOSO=00, FILTRANDO=01, PRESSIONADO=10 and SOLTANDO=11, plus an 8-bit cycle counter cnt and a 4-bit candidate register cand.
REQ-013 In OCIOSO, if S is one-hot, the FSM SHALL go to FILTRANDO with cand<=S and cnt<=1; if S is zero or multi-hot, it SHALL stay in OCIOSO.
REQ-014 In FILTRANDO, if S==cand and cnt==N_DEB-1, the FSM SHALL go to PRESSIONADO, set botoes<=cand and pulse jogada for exactly that next cycle.
REQ-015 In FILTRANDO, if S==cand and cnt<N_DEB-1, cnt SHALL increment.
REQ-016 In FILTRANDO, if S!=cand, the FSM SHALL return to OCIOSO with cnt<=0.
REQ-017 In PRESSIONADO, botoes SHALL hold cand.
REQ-018 In PRESSIONADO, S==0 SHALL move the FSM to SOLTANDO with cnt<=1; any nonzero S (including a different or multi-hot value) SHALL be ignored.
REQ-019 In SOLTANDO, if S==0 and cnt==N_DEB-1, the FSM SHALL go to OCIOSO with botoes<=0000.
REQ-020 In SOLTANDO, if S==0 and cnt<N_DEB-1, cnt SHALL increment.
REQ-021 In SOLTANDO, if S!=0, the FSM SHALL return to PRESSIONADO with cnt<=0, botoes unchanged and no new jogada pulse.
REQ-022 Latency SHALL be 2+N_DEB rising edges from the first edge sampling a stable raw press to botoes/jogada asserting; release latency SHALL also be 2+N_DEB edges.
REQ-023 Glitches shorter than N_DEB cycles SHALL never change botoes or generate jogada.
REQ-024 jogada SHALL fire at most once per accepted press, and never twice within 2*N_DEB cycles.
REQ-025 jogar SHALL use an independent level debouncer (same N_DEB, own counter): the debounced level flips only after N_DEB consecutive cycles of the opposite synchronized value.
REQ-026 jogar SHALL pulse for one cycle on each 0->1 transition of the debounced level.
REQ-027 db_multiplo SHALL be combinational from S (popcount(S)>1).
REQ-028 db_estado SHALL equal the state register.
REQ-029 jogada and jogar SHALL be registered outputs; simultaneous button and jogar acceptance SHALL pulse both in the same cycle.
REQ-030 Counters SHALL saturate rather than wrap.

Reset
REQ-031 While reset=0, the block SHALL hold botoes=0000, jogada=0, jogar=0, db_estado=00, cnt=0, cand=0000, synchronizers=0 and debounced jogar level=0.
REQ-032 Reset asserted mid-press SHALL abort immediately.
REQ-033 After reset deasserts with a button still held, a full 2+N_DEB filtering SHALL occur before acceptance.

Verification (N_DEB=4)
REQ-034 botoes_in 0000->0010 held -> botoes=0010 and a single jogada pulse at the 6th edge; db_estado sequence 00,01,10.
REQ-035 botoes_in=0100 for 3 cycles then 0000 -> botoes stays 0000, no jogada, FSM returns to 00.
REQ-036 botoes_in=0011 held -> db_multiplo=1, botoes=0000, FSM stays 00, no jogada.
REQ-037 Accepted 1000, then a 2-cycle release glitch -> FSM 10->11->10, botoes=1000 throughout, no second jogada; a full release clears botoes after 6 edges.
REQ-038 jogar_in held high 10 cycles -> exactly one jogar pulse at the 6th edge; release then re-press -> a second pulse.
REQ-039 reset=0 pulsed during FILTRANDO with 0001 held -> outputs 0 at once; after release, jogada occurs 6 edges later.
